// File: rtl/fft_bfly_stage_pipe.sv
// Streaming radix-2 butterfly, x0 = a + W*b and x1 = a - W*b, in a 3-stage valid/ready pipeline.
// Define FFT_BFLY_ROUND_EN for round-half-up in place of truncation (stage-2 shift and 1/2 scale).
module fft_bfly_stage_pipe #(
   parameter int unsigned bits    = 16,
   parameter int unsigned fix_bit = 7,
   parameter int unsigned LOG2N   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*bits-1:0] in_a,
   input  logic [2*bits-1:0] in_b,
   input  logic [2*bits-1:0] in_tw,
   input  logic              inverse,
   input  logic              scale,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*bits-1:0] out_x0,
   output logic [2*bits-1:0] out_x1,
   output logic              out_last,
   output logic [7:0]        frame_cnt,
   input  logic              clr_ovf,
   output logic              ovf
);

   localparam int unsigned PW = 2*bits + 1;
   localparam int unsigned PB = bits + 1;
   localparam int unsigned SW = bits + 2;
   localparam int unsigned CW = (LOG2N > 1) ? LOG2N - 1 : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((64'd1 << (LOG2N - 1)) - 64'd1);

   localparam logic signed [bits-1:0] SMIN = {1'b1, {(bits-1){1'b0}}};
   localparam logic signed [bits-1:0] SMAX = {1'b0, {(bits-1){1'b1}}};
   localparam logic signed [SW-1:0] SW_MIN = SW'(SMIN);
   localparam logic signed [SW-1:0] SW_MAX = SW'(SMAX);

`ifdef FFT_BFLY_ROUND_EN
   localparam logic signed [PW-1:0] P_RND = PW'((64'd1 << fix_bit) >> 1);
   localparam logic signed [SW-1:0] S_RND = SW'(1);
`else
   localparam logic signed [PW-1:0] P_RND = '0;
   localparam logic signed [SW-1:0] S_RND = '0;
`endif

   function automatic logic signed [SW-1:0] combine(input logic signed [bits-1:0] a,
                                                    input logic signed [PB-1:0]   p,
                                                    input logic                   sub,
                                                    input logic                   sc);
      logic signed [SW-1:0] s;
      s = sub ? SW'(a) - SW'(p) : SW'(a) + SW'(p);
      if (sc) s = (s + S_RND) >>> 1;
      return s;
   endfunction

   function automatic logic signed [bits-1:0] clamp(input logic signed [SW-1:0] v);
      if (v > SW_MAX) return SMAX;
      if (v < SW_MIN) return SMIN;
      return bits'(v);
   endfunction

   function automatic logic clipped(input logic signed [SW-1:0] v);
      return (v > SW_MAX) || (v < SW_MIN);
   endfunction

   // Flow control: a full output stage blocks every stage behind it, bubbles included.
   logic advance, accept;
   logic v1_q, v2_q, v3_q;

   assign advance  = ~v3_q | out_ready;
   assign in_ready = reset & advance;
   assign accept   = in_valid & in_ready;

   // Stage 1: capture operands, conjugate twiddle in inverse mode.
   logic signed [bits-1:0] in_wi, wi_eff;
   logic signed [bits-1:0] ar1_q, ai1_q, br1_q, bi1_q, wr1_q, wi1_q;
   logic                   sc1_q, last1_q;
   logic [CW-1:0]          bf_cnt_q;

   assign in_wi = in_tw[bits-1:0];

   always_comb begin
      wi_eff = in_wi;
      if (inverse) wi_eff = (in_wi == SMIN) ? SMAX : -in_wi;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q     <= 1'b0;
         ar1_q    <= '0;
         ai1_q    <= '0;
         br1_q    <= '0;
         bi1_q    <= '0;
         wr1_q    <= '0;
         wi1_q    <= '0;
         sc1_q    <= 1'b0;
         last1_q  <= 1'b0;
         bf_cnt_q <= '0;
      end else begin
         if (advance) begin
            v1_q    <= accept;
            ar1_q   <= in_a[2*bits-1:bits];
            ai1_q   <= in_a[bits-1:0];
            br1_q   <= in_b[2*bits-1:bits];
            bi1_q   <= in_b[bits-1:0];
            wr1_q   <= in_tw[2*bits-1:bits];
            wi1_q   <= wi_eff;
            sc1_q   <= scale;
            last1_q <= (bf_cnt_q == CNT_LAST);
         end
         if (accept) bf_cnt_q <= (bf_cnt_q == CNT_LAST) ? '0 : bf_cnt_q + CW'(1);
      end
   end

   // Stage 2: complex multiply p = W*b, scaled back by the twiddle's fractional bits.
   logic signed [PW-1:0] pr_full, pi_full;
   logic signed [PB-1:0] pr_d, pi_d;
   logic signed [bits-1:0] ar2_q, ai2_q;
   logic signed [PB-1:0]   pr2_q, pi2_q;
   logic                   sc2_q, last2_q;

   always_comb begin
      pr_full = PW'(br1_q) * PW'(wr1_q) - PW'(bi1_q) * PW'(wi1_q);
      pi_full = PW'(br1_q) * PW'(wi1_q) + PW'(bi1_q) * PW'(wr1_q);
      pr_d    = PB'((pr_full + P_RND) >>> fix_bit);
      pi_d    = PB'((pi_full + P_RND) >>> fix_bit);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2_q    <= 1'b0;
         ar2_q   <= '0;
         ai2_q   <= '0;
         pr2_q   <= '0;
         pi2_q   <= '0;
         sc2_q   <= 1'b0;
         last2_q <= 1'b0;
      end else if (advance) begin
         v2_q    <= v1_q;
         ar2_q   <= ar1_q;
         ai2_q   <= ai1_q;
         pr2_q   <= pr_d;
         pi2_q   <= pi_d;
         sc2_q   <= sc1_q;
         last2_q <= last1_q;
      end
   end

   // Stage 3: sum/difference, optional halving, saturation.
   logic signed [SW-1:0]   s0r, s0i, s1r, s1i;
   logic                   sat;
   logic signed [bits-1:0] x0r_q, x0i_q, x1r_q, x1i_q;
   logic                   last3_q, ovf_q;
   logic [7:0]             frame_q;

   always_comb begin
      s0r = combine(ar2_q, pr2_q, 1'b0, sc2_q);
      s0i = combine(ai2_q, pi2_q, 1'b0, sc2_q);
      s1r = combine(ar2_q, pr2_q, 1'b1, sc2_q);
      s1i = combine(ai2_q, pi2_q, 1'b1, sc2_q);
      sat = clipped(s0r) | clipped(s0i) | clipped(s1r) | clipped(s1i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v3_q    <= 1'b0;
         x0r_q   <= '0;
         x0i_q   <= '0;
         x1r_q   <= '0;
         x1i_q   <= '0;
         last3_q <= 1'b0;
      end else if (advance) begin
         v3_q <= v2_q;
         if (v2_q) begin
            x0r_q   <= clamp(s0r);
            x0i_q   <= clamp(s0i);
            x1r_q   <= clamp(s1r);
            x1i_q   <= clamp(s1i);
            last3_q <= last2_q;
         end
      end
   end

   // A new saturation takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q   <= 1'b0;
         frame_q <= '0;
      end else begin
         if (advance && v2_q && sat) ovf_q <= 1'b1;
         else if (clr_ovf)           ovf_q <= 1'b0;
         if (v3_q && out_ready && last3_q) frame_q <= frame_q + 8'd1;
      end
   end

   assign out_valid = v3_q;
   assign out_x0    = {x0r_q, x0i_q};
   assign out_x1    = {x1r_q, x1i_q};
   assign out_last  = last3_q;
   assign frame_cnt = frame_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bfly_stage_pipe.sv
// Scoreboard bench for fft_bfly_stage_pipe: accepted pairs push model results, a monitor pops
// and compares every output handshake. Model follows FFT_BFLY_ROUND_EN when defined.
module tb_fft_bfly_stage_pipe;

   localparam int BITS = 16;
   localparam int FIX  = 7;
   localparam int HALF = 16;

   typedef struct {
      logic [31:0] x0;
      logic [31:0] x1;
      logic        last;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] in_tw = '0;
   logic        inverse = 1'b0;
   logic        scale = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_x0;
   logic [31:0] out_x1;
   logic        out_last;
   logic [7:0]  frame_cnt;
   logic        clr_ovf = 1'b0;
   logic        ovf;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          model_cnt = 0;
   int          n_last = 0;
   bit          done = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_x0, prev_x1;

   fft_bfly_stage_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tw     (in_tw),
      .inverse   (inverse),
      .scale     (scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x0    (out_x0),
      .out_x1    (out_x1),
      .out_last  (out_last),
      .frame_cnt (frame_cnt),
      .clr_ovf   (clr_ovf),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   function automatic longint fdiv(input longint v, input int sh);
      longint d = longint'(1) << sh;
      longint q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint wrap(input longint v, input int w);
      longint m = longint'(1) << w;
      longint r = v % m;
      if (r < 0) r = r + m;
      if (r >= m / 2) r = r - m;
      return r;
   endfunction

   function automatic longint sx(input logic [15:0] x);
      return longint'($signed(x));
   endfunction

   function automatic logic [31:0] pk(input longint re, input longint im);
      logic [15:0] r, i;
      r = re[15:0];
      i = im[15:0];
      return {r, i};
   endfunction

   // Reference: complex arithmetic on wide integers, floor shifts, clamp to 16 bits.
   function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] tw, input logic inv, input logic sc,
                                     input logic last);
      exp_t   e;
      longint ar, ai, br, bi, wr, wi, pr, pi;
      longint s[4];
      ar = sx(a[31:16]);  ai = sx(a[15:0]);
      br = sx(b[31:16]);  bi = sx(b[15:0]);
      wr = sx(tw[31:16]); wi = sx(tw[15:0]);
      if (inv) wi = (wi == -32768) ? 32767 : -wi;
      pr = br * wr - bi * wi;
      pi = br * wi + bi * wr;
`ifdef FFT_BFLY_ROUND_EN
      pr = pr + (longint'(1) << (FIX - 1));
      pi = pi + (longint'(1) << (FIX - 1));
`endif
      pr = wrap(fdiv(pr, FIX), BITS + 1);
      pi = wrap(fdiv(pi, FIX), BITS + 1);
      s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
      e.sat = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (sc) begin
`ifdef FFT_BFLY_ROUND_EN
            s[k] = s[k] + 1;
`endif
            s[k] = fdiv(s[k], 1);
         end
         if (s[k] > 32767) begin s[k] = 32767; e.sat = 1'b1; end
         else if (s[k] < -32768) begin s[k] = -32768; e.sat = 1'b1; end
      end
      e.x0   = pk(s[0], s[1]);
      e.x1   = pk(s[2], s[3]);
      e.last = last;
      return e;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   function automatic logic [31:0] rnd_tw();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return pk(longint'($urandom_range(0, 400)) - 200, longint'($urandom_range(0, 400)) - 200);
   endfunction

   // Stimulus side of the scoreboard.
   always @(negedge clk) begin
      if (reset && in_valid && in_ready) begin
         exp_q.push_back(make_exp(in_a, in_b, in_tw, inverse, scale,
                                  (model_cnt % HALF) == HALF - 1));
         model_cnt++;
      end
   end

   // Monitor: pop on every output handshake; held outputs must not change.
   always @(negedge clk) begin
      if (!reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 1);
            check("hold_x0", 64'(out_x0), 64'(prev_x0));
            check("hold_x1", 64'(out_x1), 64'(prev_x1));
         end
         if (out_valid && out_ready) begin
            if (out_last) n_last++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got x0=%h expected no output", out_x0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_x0", 64'(out_x0), 64'(mon_e.x0));
               check("sb_x1", 64'(out_x1), 64'(mon_e.x1));
               check("sb_last", 64'(out_last), 64'(mon_e.last));
               if (mon_e.sat) check("sb_ovf", 64'(ovf), 1);
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_x0   = out_x0;
         prev_x1   = out_x1;
      end
   end

   // All driving tasks start and end just after a rising edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] tw,
                       input logic inv, input logic sc);
      bit ok = 0;
      int n  = 0;
      in_a = a; in_b = b; in_tw = tw; inverse = inv; scale = sc; in_valid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!ok && n > 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
            ok = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input logic [31:0] e0, input logic [31:0] e1, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check({nm, "_latency"}, 64'(n), 3);
      check({nm, "_x0"}, 64'(out_x0), 64'(e0));
      check({nm, "_x1"}, 64'(out_x1), 64'(e1));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      exp_q.delete();
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_frame_cnt", 64'(frame_cnt), 0);
      check("rst_ovf", 64'(ovf), 0);
      check("rst_x0", 64'(out_x0), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      model_cnt = 0;
      n_last    = 0;
      reset     = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("por_out_valid", 64'(out_valid), 0);
      check("por_in_ready", 64'(in_ready), 0);
      check("por_frame_cnt", 64'(frame_cnt), 0);
      check("por_ovf", 64'(ovf), 0);
      check("por_last", 64'(out_last), 0);
      reset = 1'b1;

      send(pk(100, 50), pk(20, -10), pk(128, 0), 1'b0, 1'b0);
      wait_out(pk(120, 40), pk(80, 60), "basic");
      check("basic_ovf", 64'(ovf), 0);
      send(pk(100, 50), pk(20, -10), pk(128, 0), 1'b0, 1'b1);
      wait_out(pk(60, 20), pk(40, 30), "scale");
      send(pk(100, 50), pk(20, -10), pk(0, -128), 1'b0, 1'b0);
      wait_out(pk(90, 30), pk(110, 70), "tw_negj");
      send(pk(100, 50), pk(20, -10), pk(0, 128), 1'b1, 1'b0);
      wait_out(pk(90, 30), pk(110, 70), "tw_inv");
      check("inv_ovf", 64'(ovf), 0);

      send(pk(32767, 0), pk(32767, 0), pk(128, 0), 1'b0, 1'b0);
      wait_out(pk(32767, 0), pk(0, 0), "sat");
      check("sat_ovf", 64'(ovf), 1);
      repeat (3) @(posedge clk);
      #1;
      check("sat_ovf_held", 64'(ovf), 1);
      clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
      check("ovf_cleared", 64'(ovf), 0);

      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send($urandom, $urandom, rnd_tw(), 1'b0, 1'(i % 2));
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 0);
            check("bp_out_valid", 64'(out_valid), 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      do_reset();
      for (int i = 0; i < 32; i++)
         send($urandom, $urandom, rnd_tw(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
      check("frame_cnt_2", 64'(frame_cnt), 2);
      check("frame_lasts", 64'(n_last), 2);

      for (int i = 0; i < 5; i++) send($urandom, $urandom, rnd_tw(), 1'b0, 1'b0);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send($urandom, $urandom, rnd_tw(), 1'b0, 1'b0);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) send($urandom, $urandom, rnd_tw(), 1'b0, 1'b1);
      drain();
      check("rst_frame_cnt_1", 64'(frame_cnt), 1);
      check("rst_frame_lasts", 64'(n_last), 1);

      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send($urandom, $urandom, rnd_tw(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_bfly_stage_pipe.md
Name: fft_bfly_stage_pipe

Overview:
Parametrised, streaming radix-2 butterfly engine. It is the successor to the fixed unity-twiddle 2-point DFT front end.
- Accepts one complex pair (a, b) plus a twiddle per handshake and computes x0 = a + W·b and x1 = a − W·b.
- Three-stage stall-able pipeline with valid/ready flow control.
- Optional per-stage 1/2 scaling, inverse (conjugate-twiddle) mode, saturation with a sticky overflow flag, and frame tracking.
- One instance per FFT stage; the address/twiddle sequencer sits upstream and the stage memory sits downstream.

Parameters:
- bits, 16, width of each real/imag component (two's complement).
- fix_bit, 7, fractional bits of twiddle; 1.0 = 2^fix_bit.
- LOG2N, 5, log2 of FFT size; a frame is 2^(LOG2N-1) butterflies.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input pair valid.
- in_ready, output, 1, engine accepts the pair this cycle.
- in_a, input, 2*bits, complex a: {real[2*bits-1:bits], imag[bits-1:0]}.
- in_b, input, 2*bits, complex b, same packing.
- in_tw, input, 2*bits, twiddle W, same packing, Q(bits-fix_bit).fix_bit.
- inverse, input, 1, sampled with the pair; 1 = use conj(W).
- scale, input, 1, sampled with the pair; 1 = divide both results by 2.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_x0, output, 2*bits, a + W·b.
- out_x1, output, 2*bits, a − W·b.
- out_last, output, 1, result belongs to the last butterfly of a frame.
- frame_cnt, output, 8, completed frames, wraps 255→0.
- clr_ovf, input, 1, synchronous clear of ovf.
- ovf, output, 1, sticky saturation flag.

Behaviour:
- Reset (reset=0, async): all stage valids, out_x0/out_x1, out_last, frame_cnt, ovf, and the butterfly counter go to 0. While reset is low, in_ready=0. In-flight data is discarded; no partial frame survives.
- Pipeline advance: advance = ~v3 | out_ready, and in_ready = advance.
  - On advance, every stage shifts forward; v1 <= in_valid, and the input is accepted iff in_valid & in_ready.
  - Bubbles propagate; there is no bubble collapse.
- Latency: 3 cycles from accept to out_valid with out_ready held high. Throughput is 1 pair/cycle.
- Stage 1: registers a, b, W, scale, last.
  - inverse=1 negates W imag, saturating: −2^(bits-1) → 2^(bits-1)−1.
  - last = (butterfly counter == 2^(LOG2N-1)−1). The counter increments per accept and wraps to 0 after last.
- Stage 2: complex multiply p = W·b.
  - Real = br·wr − bi·wi; imag = br·wi + bi·wr.
  - Each is computed at full 2*bits+1 width, arithmetically shifted right by fix_bit (truncation), then kept at bits+1 width. a is delayed to match.
- Stage 3: s0 = a + p and s1 = a − p, computed at bits+2 width.
  - If scale=1, arithmetic shift right by 1.
  - Saturate each component to [−2^(bits-1), 2^(bits-1)−1].
  - Any clamp sets ovf on the cycle the result enters stage 3.
- ovf: sticky until clr_ovf=1. If clr_ovf and a new saturation occur in the same cycle, the set wins.
- Outputs hold stable while out_valid & ~out_ready.
- frame_cnt increments on each output handshake with out_last=1.

Optional Feature:
- Macro: FFT_BFLY_ROUND_EN.
- Defined: round-half-up. Add 2^(fix_bit-1) before the stage-2 shift, and add 1 before the stage-3 scale shift (only when scale=1). Rounding occurs before saturation.
- Undefined: truncation, as described above.
- Latency is identical in both builds.

Test Plan:
- Basic, tw=(128,0), a=(100,50), b=(20,-10), scale=0 → 3 cycles later out_x0=(120,40), out_x1=(80,60), ovf=0; repeat with scale=1 → (60,20), (40,30).
- Twiddle −j, tw=(0,-128), same a, b → out_x0=(90,30), out_x1=(110,70). Then inverse=1 with tw=(0,128) → identical results.
- Saturation, a=(32767,0), b=(32767,0), tw=(128,0) → out_x0=(32767,0), out_x1=(0,0), ovf=1 and held; pulse clr_ovf → ovf=0 next cycle.
- Backpressure: stream 6 pairs with out_ready=0 for 5 cycles → in_ready drops once 3 are held, out_x0 stays stable. Release → all 6 emerge in order, none lost or duplicated.
- Frame (LOG2N=5): 32 back-to-back pairs → out_last high on outputs 16 and 32 only; frame_cnt=2.
- Reset mid-stream: drop reset while 3 results are in flight → out_valid=0, frame_cnt=0, and the counter restarts so out_last lands on the 16th pair after release.
